// File: rtl/snake_step_ctrl.sv
// Step controller for an 8x8 snake game: clears the field, then advances the
// snake one cell every TICK_DIV+3 cycles, and drives a one-cell field write port.
module snake_step_ctrl #(
    parameter int TICK_DIV = 16,
    parameter int MAX_LEN  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_dir_valid,
    input  logic [1:0] i_dir,
    input  logic [2:0] i_food_x,
    input  logic [2:0] i_food_y,
    output logic [2:0] o_head_x,
    output logic [2:0] o_head_y,
    output logic [1:0] o_cur_dir,
    output logic [3:0] o_length,
    output logic       o_wr_en,
    output logic [2:0] o_wr_x,
    output logic [2:0] o_wr_y,
    output logic       o_wr_val,
    output logic       o_step_pulse,
    output logic       o_eat_pulse,
    output logic       o_game_over,
    output logic       o_busy,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_INIT, S_RUN, S_MOVE, S_ERASE, S_DRAW, S_OVER
    } state_t;

    localparam logic [3:0]  LP_MAX_LEN   = 4'(MAX_LEN);
    localparam logic [15:0] LP_TICK_LAST = 16'(TICK_DIV - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  r_clr_cnt;
    logic [15:0] r_tick;
    logic [2:0]  r_head_x;
    logic [2:0]  r_head_y;
    logic [1:0]  r_cur_dir;
    logic [1:0]  r_pend_dir;
    logic [3:0]  r_len;
    logic [2:0]  r_seg_x [MAX_LEN];
    logic [2:0]  r_seg_y [MAX_LEN];
    logic [2:0]  r_nx;
    logic [2:0]  r_ny;
    logic        r_grow;

    logic [2:0]  w_mv_x;
    logic [2:0]  w_mv_y;
    logic [2:0]  w_tail_x;
    logic [2:0]  w_tail_y;
    logic [1:0]  w_ref_dir;
    logic        w_dir_ok_state;
    logic        w_dir_accept;
    logic        w_grow;
    logic        w_hit;

    // INIT forces the applied direction to right, so reversal is judged against that.
    assign w_ref_dir      = (r_state == S_INIT) ? 2'b01 : r_cur_dir;
    assign w_dir_ok_state = (r_state != S_IDLE) && (r_state != S_CLEAR) && (r_state != S_OVER);
    assign w_dir_accept   = i_dir_valid && w_dir_ok_state && (i_dir != (w_ref_dir ^ 2'b10));

    always_comb begin
        w_mv_x = r_head_x;
        w_mv_y = r_head_y;
        case (r_pend_dir)
            2'b00:   w_mv_y = r_head_y - 3'd1;
            2'b01:   w_mv_x = r_head_x + 3'd1;
            2'b10:   w_mv_y = r_head_y + 3'd1;
            default: w_mv_x = r_head_x - 3'd1;
        endcase
    end

    assign w_grow = (w_mv_x == i_food_x) && (w_mv_y == i_food_y) && (r_len < LP_MAX_LEN);

    // The tail vacates its cell during a non-growing step, so it cannot be hit.
    always_comb begin
        w_hit    = 1'b0;
        w_tail_x = r_seg_x[0];
        w_tail_y = r_seg_y[0];
        for (int i = 0; i < MAX_LEN; i++) begin
            if (4'(i) == r_len - 4'd1) begin
                w_tail_x = r_seg_x[i];
                w_tail_y = r_seg_y[i];
            end
            if ((4'(i) < r_len) && (r_seg_x[i] == w_mv_x) && (r_seg_y[i] == w_mv_y)
                && (w_grow || (4'(i) != r_len - 4'd1))) begin
                w_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_OVER: if (i_start) w_next_state = S_CLEAR;
            S_CLEAR:        if (r_clr_cnt == 6'd63) w_next_state = S_INIT;
            S_INIT:         w_next_state = S_RUN;
            S_RUN:          if (r_tick == LP_TICK_LAST) w_next_state = S_MOVE;
            S_MOVE: begin
                if (w_hit)       w_next_state = S_OVER;
                else if (w_grow) w_next_state = S_DRAW;
                else             w_next_state = S_ERASE;
            end
            S_ERASE:        w_next_state = S_DRAW;
            S_DRAW:         w_next_state = S_RUN;
            default:        w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_wr_en      = 1'b0;
        o_wr_x       = 3'd0;
        o_wr_y       = 3'd0;
        o_wr_val     = 1'b0;
        o_step_pulse = 1'b0;
        o_eat_pulse  = 1'b0;
        case (r_state)
            S_CLEAR: begin
                o_wr_en = 1'b1;
                o_wr_x  = r_clr_cnt[2:0];
                o_wr_y  = r_clr_cnt[5:3];
            end
            S_INIT: begin
                o_wr_en  = 1'b1;
                o_wr_val = 1'b1;
            end
            S_ERASE: begin
                o_wr_en = 1'b1;
                o_wr_x  = w_tail_x;
                o_wr_y  = w_tail_y;
            end
            S_DRAW: begin
                o_wr_en      = 1'b1;
                o_wr_x       = r_nx;
                o_wr_y       = r_ny;
                o_wr_val     = 1'b1;
                o_step_pulse = 1'b1;
                o_eat_pulse  = r_grow;
            end
            default: ;
        endcase
    end

    assign o_game_over = (r_state == S_OVER);
    assign o_busy      = (r_state != S_IDLE) && (r_state != S_OVER);
    assign o_head_x    = r_head_x;
    assign o_head_y    = r_head_y;
    assign o_cur_dir   = r_cur_dir;
    assign o_length    = r_len;
    assign o_state     = r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_clr_cnt  <= 6'd0;
            r_tick     <= 16'd0;
            r_head_x   <= 3'd0;
            r_head_y   <= 3'd0;
            r_cur_dir  <= 2'b01;
            r_pend_dir <= 2'b01;
            r_len      <= 4'd1;
            r_nx       <= 3'd0;
            r_ny       <= 3'd0;
            r_grow     <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= 3'd0;
                r_seg_y[i] <= 3'd0;
            end
        end else begin
            r_state <= w_next_state;
            if (w_dir_accept) r_pend_dir <= i_dir;
            case (r_state)
                S_IDLE, S_OVER: r_clr_cnt <= 6'd0;
                S_CLEAR:        r_clr_cnt <= r_clr_cnt + 6'd1;
                S_INIT: begin
                    r_head_x   <= 3'd0;
                    r_head_y   <= 3'd0;
                    r_len      <= 4'd1;
                    r_cur_dir  <= 2'b01;
                    r_seg_x[0] <= 3'd0;
                    r_seg_y[0] <= 3'd0;
                    r_tick     <= 16'd0;
                    if (!w_dir_accept) r_pend_dir <= 2'b01;
                end
                S_RUN:  r_tick <= r_tick + 16'd1;
                S_MOVE: begin
                    r_cur_dir <= r_pend_dir;
                    r_nx      <= w_mv_x;
                    r_ny      <= w_mv_y;
                    r_grow    <= w_grow;
                end
                S_DRAW: begin
                    r_head_x   <= r_nx;
                    r_head_y   <= r_ny;
                    r_seg_x[0] <= r_nx;
                    r_seg_y[0] <= r_ny;
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        r_seg_x[i] <= r_seg_x[i-1];
                        r_seg_y[i] <= r_seg_y[i-1];
                    end
                    if (r_grow) r_len <= r_len + 4'd1;
                    r_tick <= 16'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Bench for snake_step_ctrl: directed game scenarios plus random play, checked
// against a coordinate-queue model of the snake.
module tb_snake_step_ctrl;

    localparam int TD = 4;
    localparam int ML = 6;

    logic       clk = 1'b0;
    logic       rst, start, dir_valid;
    logic [1:0] dir;
    logic [2:0] food_x, food_y;
    logic [2:0] head_x, head_y;
    logic [1:0] cur_dir;
    logic [3:0] length;
    logic       wr_en, wr_val;
    logic [2:0] wr_x, wr_y;
    logic       step_pulse, eat_pulse, game_over, busy;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    snake_step_ctrl #(.TICK_DIV(TD), .MAX_LEN(ML)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_dir_valid(dir_valid), .i_dir(dir),
        .i_food_x(food_x), .i_food_y(food_y), .o_head_x(head_x), .o_head_y(head_y),
        .o_cur_dir(cur_dir), .o_length(length), .o_wr_en(wr_en), .o_wr_x(wr_x),
        .o_wr_y(wr_y), .o_wr_val(wr_val), .o_step_pulse(step_pulse), .o_eat_pulse(eat_pulse),
        .o_game_over(game_over), .o_busy(busy), .o_state(state_dbg)
    );

    int n_vec = 0;
    int n_err = 0;

    // Snake model: element 0 is the head, last element is the tail.
    int         m_x[$];
    int         m_y[$];
    logic [1:0] m_cur, m_pend;
    logic       m_over;
    logic [6:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] accept(input logic [1:0] cur, input logic [1:0] pend,
                                          input logic dv, input logic [1:0] d);
        return (dv && (d != (cur ^ 2'b10))) ? d : pend;
    endfunction

    function automatic logic [5:0] next_cell(input int hx, input int hy, input logic [1:0] d);
        int x, y;
        x = hx;
        y = hy;
        if (d == 2'd0)      y = y - 1;
        else if (d == 2'd1) x = x + 1;
        else if (d == 2'd2) y = y + 1;
        else                x = x - 1;
        x = (x + 8) % 8;
        y = (y + 8) % 8;
        return {3'(y), 3'(x)};
    endfunction

    task automatic game_start(input logic [2:0] fx, input logic [2:0] fy);
        logic [6:0] e;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                exp_q.push_back({1'b0, 3'(y), 3'(x)});
        food_x = fx;
        food_y = fy;
        dir_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 64; c++) begin
            e = exp_q.pop_front();
            chk("clr_wr_en", wr_en, 1);
            chk("clr_addr", {wr_val, wr_y, wr_x}, e);
            chk("clr_busy", busy, 1);
            @(negedge clk);
        end
        chk("init_write", {wr_en, wr_val, wr_y, wr_x}, {2'b11, 6'd0});
        @(negedge clk);
        chk("init_head", {head_y, head_x}, 6'd0);
        chk("init_len", length, 1);
        chk("init_dir", cur_dir, 2'b01);
        chk("run_no_write", wr_en, 0);
        m_x = {};
        m_y = {};
        m_x.push_back(0);
        m_y.push_back(0);
        m_cur = 2'b01;
        m_pend = 2'b01;
        m_over = 1'b0;
    endtask

    // Entered and left at a negedge in the first RUN cycle (or OVER on collision).
    task automatic do_step(input logic dv0, input logic [1:0] d0, input logic dv1,
                           input logic [1:0] d1, input logic [2:0] fx, input logic [2:0] fy,
                           input logic ps);
        int hx, hy, len, cyc, writes, erases, nx, ny;
        logic grow, hit, done;
        logic [5:0] er_addr, dr_addr, nc;
        hx = m_x[0];
        hy = m_y[0];
        len = m_x.size();
        food_x = fx;
        food_y = fy;
        cyc = 0; writes = 0; erases = 0; done = 1'b0;
        er_addr = '0; dr_addr = '0;
        while (!done && cyc < TD + 8) begin
            if (cyc == 0) begin
                dir_valid = dv0; dir = d0; start = ps;
                m_pend = accept(m_cur, m_pend, dv0, d0);
            end else if (cyc == 1) begin
                dir_valid = dv1; dir = d1; start = 1'b0;
                m_pend = accept(m_cur, m_pend, dv1, d1);
            end else begin
                dir_valid = 1'b0; start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (wr_en) begin
                writes++;
                if (wr_val) dr_addr = {wr_y, wr_x};
                else begin erases++; er_addr = {wr_y, wr_x}; end
            end
            if (step_pulse || game_over) done = 1'b1;
        end
        dir_valid = 1'b0;
        start = 1'b0;
        chk("step_done", done, 1);
        if (!done) return;

        nc = next_cell(hx, hy, m_pend);
        nx = int'(nc[2:0]);
        ny = int'(nc[5:3]);
        grow = (nx == fx) && (ny == fy) && (len < ML);
        hit = 1'b0;
        for (int i = 0; i < len; i++)
            if ((grow || i != len - 1) && m_x[i] == nx && m_y[i] == ny) hit = 1'b1;
        m_cur = m_pend;

        if (hit) begin
            chk("over_cycle", cyc, TD + 1);
            chk("over_flag", game_over, 1);
            chk("over_busy", busy, 0);
            chk("over_no_wr", writes, 0);
            chk("over_head", {head_y, head_x}, {3'(hy), 3'(hx)});
            m_over = 1'b1;
        end else begin
            chk("step_period", cyc + 1, grow ? TD + 2 : TD + 3);
            chk("step_pulse", step_pulse, 1);
            chk("eat_pulse", eat_pulse, grow);
            chk("step_writes", writes, grow ? 1 : 2);
            chk("erase_count", erases, grow ? 0 : 1);
            if (!grow) chk("erase_addr", er_addr, {3'(m_y[len-1]), 3'(m_x[len-1])});
            chk("draw_addr", dr_addr, {3'(ny), 3'(nx)});
            m_x.push_front(nx);
            m_y.push_front(ny);
            if (!grow) begin
                void'(m_x.pop_back());
                void'(m_y.pop_back());
            end
            @(negedge clk);
            chk("head", {head_y, head_x}, {3'(ny), 3'(nx)});
            chk("length", length, m_x.size());
            chk("cur_dir", cur_dir, m_cur);
            chk("run_busy", busy, 1);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic dv0, dv1;
        logic [1:0] d0, d1, p;
        logic [2:0] fx, fy;
        logic [5:0] nc;
        rst = 1'b1; start = 1'b0; dir_valid = 1'b0; dir = 2'd0;
        food_x = 3'd7; food_y = 3'd7; m_over = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_head", {head_y, head_x}, 6'd0);
        chk("rst_dir", cur_dir, 2'b01);
        chk("rst_len", length, 1);
        chk("rst_outs", {wr_en, step_pulse, eat_pulse, game_over, busy}, 5'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // rst wins over start
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", busy, 0);
        @(negedge clk);
        chk("rst_prio_idle", {busy, wr_en}, 2'd0);

        // eight plain steps wrap the head back to (0,0); start mid-RUN is ignored
        game_start(3'd0, 3'd7);
        for (int s = 0; s < 8; s++) do_step(1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd7, s == 3);
        chk("wrap_head", {head_y, head_x}, 6'd0);
        for (int s = 0; s < 3; s++) do_step(1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 3'd7, 1'b0);
        do_step(1'b1, 2'd3, 1'b0, 2'd0, 3'd0, 3'd7, 1'b0);
        chk("reverse_dropped", cur_dir, 2'b01);
        do_step(1'b1, 2'd2, 1'b1, 2'd0, 3'd0, 3'd7, 1'b0);
        chk("last_dir_wins", {cur_dir, head_y, head_x}, {2'b00, 3'd7, 3'd4});
        pulse_rst();

        // rst in the middle of CLEAR
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("clr_addr30", {wr_en, wr_y, wr_x}, {1'b1, 3'd3, 3'd6});
        pulse_rst();

        // growth, then food at the head with length at the maximum
        game_start(3'd2, 3'd0);
        do_step(1'b0, 2'd0, 1'b0, 2'd0, 3'd2, 3'd0, 1'b0);
        do_step(1'b0, 2'd0, 1'b0, 2'd0, 3'd2, 3'd0, 1'b0);
        chk("eat_len2", length, 2);
        for (int s = 3; s < 8; s++) do_step(1'b0, 2'd0, 1'b0, 2'd0, 3'(s), 3'd0, 1'b0);
        chk("full_len", length, ML);
        pulse_rst();

        // length 4 chases its own tail around a 2x2 loop without dying
        game_start(3'd7, 3'd7);
        for (int s = 1; s < 4; s++) do_step(1'b0, 2'd0, 1'b0, 2'd0, 3'(s), 3'd0, 1'b0);
        do_step(1'b1, 2'd2, 1'b0, 2'd0, 3'd7, 3'd7, 1'b0);
        do_step(1'b1, 2'd3, 1'b0, 2'd0, 3'd7, 3'd7, 1'b0);
        do_step(1'b1, 2'd0, 1'b0, 2'd0, 3'd7, 3'd7, 1'b0);
        do_step(1'b1, 2'd1, 1'b0, 2'd0, 3'd7, 3'd7, 1'b0);
        chk("tail_chase_alive", game_over, 0);
        pulse_rst();

        // length 5 in the same loop bites a non-tail segment
        game_start(3'd7, 3'd7);
        for (int s = 1; s < 5; s++) do_step(1'b0, 2'd0, 1'b0, 2'd0, 3'(s), 3'd0, 1'b0);
        do_step(1'b1, 2'd2, 1'b0, 2'd0, 3'd7, 3'd7, 1'b0);
        do_step(1'b1, 2'd3, 1'b0, 2'd0, 3'd7, 3'd7, 1'b0);
        do_step(1'b1, 2'd0, 1'b0, 2'd0, 3'd7, 3'd7, 1'b0);
        chk("collide_over", m_over, 1);
        repeat (3) begin
            @(negedge clk);
            chk("over_hold", {game_over, head_y, head_x}, {1'b1, 3'd1, 3'd3});
        end

        // random play; the first game restarts straight from OVER
        for (int g = 0; g < 3; g++) begin
            game_start(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            for (int s = 0; s < 30 && !m_over; s++) begin
                dv0 = 1'($urandom_range(0, 1));
                d0  = 2'($urandom_range(0, 3));
                dv1 = 1'($urandom_range(0, 1));
                d1  = 2'($urandom_range(0, 3));
                p   = accept(m_cur, accept(m_cur, m_pend, dv0, d0), dv1, d1);
                nc  = next_cell(m_x[0], m_y[0], p);
                if ($urandom_range(0, 1) == 1) begin
                    fx = nc[2:0];
                    fy = nc[5:3];
                end else begin
                    fx = 3'($urandom_range(0, 7));
                    fy = 3'($urandom_range(0, 7));
                end
                do_step(dv0, d0, dv1, d1, fx, fy, 1'($urandom_range(0, 1)));
            end
            if (!m_over) pulse_rst();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/snake_step_ctrl.md
SNAKE_STEP_CTRL -- requirements
Module: snake_step_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 16, giving RUN-state cycles per step (range 1..65535).
REQ-002 SHALL have parameter MAX_LEN, default 8, giving the maximum number of snake segments (range 2..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to begin a new game; honoured only in IDLE or OVER.
REQ-006 dir_valid  input  1  qualifies dir for one cycle.
REQ-007 dir  input  2  direction request: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
REQ-008 food_x, food_y  input  3 each  current food cell.
REQ-009 head_x, head_y  output  3 each  current head cell.
REQ-010 cur_dir  output  2  direction applied at the last step.
REQ-011 length  output  4  current segment count.
REQ-012 wr_en, wr_x[2:0], wr_y[2:0], wr_val  output  field write port; wr_val 1 = occupied, 0 = empty.
REQ-013 step_pulse, eat_pulse, game_over, busy  output  1 each  status outputs (see Function).

Function
REQ-014 States SHALL be IDLE, CLEAR, INIT, RUN, MOVE, ERASE, DRAW, OVER.
REQ-015 IDLE/OVER + start -> CLEAR; start SHALL be ignored in all other states.
REQ-016 CLEAR SHALL last exactly 64 cycles, wr_en=1, wr_val=0, addresses row-major (y outer, x inner) from (0,0) to (7,7), then -> INIT.
REQ-017 INIT SHALL last 1 cycle: head=(0,0), length=1, cur_dir=01, pending dir=01, segment[0]=(0,0), write 1 at (0,0), clear tick counter, -> RUN.
REQ-018 RUN SHALL count 0..TICK_DIV-1 and enter MOVE on the cycle after the count reaches TICK_DIV-1.
REQ-019 dir_valid in any state other than IDLE, CLEAR and OVER SHALL load the pending dir unless dir == cur_dir XOR 2'b10 (reversal), which SHALL be dropped; the last accepted request before MOVE wins.
REQ-020 MOVE (1 cycle) SHALL set cur_dir = pending dir and compute the next head with 3-bit modulo-8 wrap (x=7 right -> 0; y=0 up -> 7).
REQ-021 In MOVE, grow SHALL be true when next head == (food_x, food_y) and length < MAX_LEN.
REQ-022 In MOVE, collision SHALL be true when the next head equals any live segment, excluding the tail segment when grow is false.
REQ-023 collision -> OVER; else grow -> DRAW; else -> ERASE.
REQ-024 ERASE (1 cycle) SHALL write 0 at the tail segment, then -> DRAW.
REQ-025 DRAW (1 cycle) SHALL write 1 at the new head, shift the segment array (new head = segment[0]), increment length if grow, pulse step_pulse, pulse eat_pulse if grow, clear the tick counter, then -> RUN.
REQ-026 Food at the head with length == MAX_LEN SHALL count as a normal step: no growth, no eat_pulse.
REQ-027 Step period SHALL be TICK_DIV+3 cycles, or TICK_DIV+2 when growing.
REQ-028 wr_en SHALL be 1 only in CLEAR, INIT, ERASE and DRAW; ERASE and DRAW never coincide.
REQ-029 game_over SHALL be 1 throughout OVER only.
REQ-030 busy SHALL be 1 in every state except IDLE and OVER.
REQ-031 head_x/head_y SHALL hold their values in OVER.

Reset
REQ-032 rst SHALL force IDLE from any state, including mid-CLEAR and mid-step, and SHALL take priority over start.
REQ-033 rst values: head=(0,0), cur_dir=01, pending dir=01, length=1, tick counter=0, all pulses/wr_en/game_over/busy=0, segment array=(0,0).

Verification
REQ-034 TICK_DIV=4; start, no dir -> 64 clear writes, INIT writes (0,0)=1, then a step_pulse every 7 cycles; after 8 steps head=(0,0), each step preceded by an ERASE of the prior tail.
REQ-035 Head (3,0) moving right; dir=11 pulsed -> dropped, cur_dir stays 01; dir=10 then dir=00 before the same MOVE -> 00 applied, head (4,7).
REQ-036 Food at (2,0) from start -> second step has no ERASE, eat_pulse=1, length=2, step period 6 cycles.
REQ-037 Length 5 in a 2x2 loop reentering its own non-tail cell -> OVER, game_over=1, no write that cycle, head unchanged; start -> CLEAR restarts.
REQ-038 rst asserted at CLEAR address 30 -> next cycle IDLE, wr_en=0, busy=0; start mid-RUN -> no effect.
